// File: rtl/cplx_sgninv_pipe.sv
// Complex sign/rotation unit (pass, negate, conjugate, x(-j)) for the FFT datapath.
// Arithmetic is done before stage 1; the remaining stages are elastic valid/ready registers.
module cplx_sgninv_pipe #(
  parameter int DATA_WIDTH = 16,
  parameter int PIPE       = 2,
  parameter bit SAT        = 1'b1,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [1:0]            i_mode,
  input  logic [DATA_WIDTH-1:0] i_re,
  input  logic [DATA_WIDTH-1:0] i_im,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_re,
  output logic [DATA_WIDTH-1:0] o_im,
  output logic                  o_ovf,
  input  logic                  i_clr,
  output logic                  o_ovf_sticky,
  output logic [CNT_WIDTH-1:0]  o_ovf_cnt
);

  localparam logic [DATA_WIDTH-1:0] MIN_VAL = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] MAX_VAL = {1'b0, {(DATA_WIDTH-1){1'b1}}};

  // The most-negative code has no positive counterpart: clamp or leave it wrapped.
  function automatic logic [DATA_WIDTH-1:0] f_neg(input logic [DATA_WIDTH-1:0] x);
    if (x == MIN_VAL) f_neg = SAT ? MAX_VAL : MIN_VAL;
    else              f_neg = ~x + DATA_WIDTH'(1);
  endfunction

  logic [DATA_WIDTH-1:0] w_re;
  logic [DATA_WIDTH-1:0] w_im;
  logic                  w_ovf;

  always_comb begin
    w_re  = i_re;
    w_im  = i_im;
    w_ovf = 1'b0;
    case (i_mode)
      2'b00: begin
      end
      2'b01: begin
        w_re  = f_neg(i_re);
        w_im  = f_neg(i_im);
        w_ovf = (i_re == MIN_VAL) || (i_im == MIN_VAL);
      end
      2'b10: begin
        w_im  = f_neg(i_im);
        w_ovf = (i_im == MIN_VAL);
      end
      default: begin
        w_re  = i_im;
        w_im  = f_neg(i_re);
        w_ovf = (i_re == MIN_VAL);
      end
    endcase
  end

  logic [PIPE-1:0]       r_vld;
  logic [PIPE-1:0]       r_ovf;
  logic [DATA_WIDTH-1:0] r_re [PIPE];
  logic [DATA_WIDTH-1:0] r_im [PIPE];

  logic [PIPE-1:0]       w_adv;
  logic [PIPE-1:0]       w_ld;
  logic [PIPE-1:0]       w_vin;
  logic [PIPE-1:0]       w_oin;
  logic [DATA_WIDTH-1:0] w_rin [PIPE];
  logic [DATA_WIDTH-1:0] w_iin [PIPE];

  // Stage k advances when the output accepts or any later stage has a bubble.
  genvar gi;
  generate
    for (gi = 0; gi < PIPE; gi++) begin : g_stage
      if (gi == PIPE-1) begin : g_last
        assign w_adv[gi] = i_ready;
      end else begin : g_mid
        assign w_adv[gi] = i_ready | ~(&r_vld[PIPE-1:gi+1]);
      end
      if (gi == 0) begin : g_first
        assign w_vin[gi] = i_valid;
        assign w_oin[gi] = w_ovf;
        assign w_rin[gi] = w_re;
        assign w_iin[gi] = w_im;
      end else begin : g_chain
        assign w_vin[gi] = r_vld[gi-1];
        assign w_oin[gi] = r_ovf[gi-1];
        assign w_rin[gi] = r_re[gi-1];
        assign w_iin[gi] = r_im[gi-1];
      end
      assign w_ld[gi] = ~r_vld[gi] | w_adv[gi];
    end
  endgenerate

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vld <= '0;
      r_ovf <= '0;
      for (int k = 0; k < PIPE; k++) begin
        r_re[k] <= '0;
        r_im[k] <= '0;
      end
    end else begin
      for (int k = 0; k < PIPE; k++) begin
        if (w_ld[k]) begin
          r_vld[k] <= w_vin[k];
          if (w_vin[k]) begin
            r_ovf[k] <= w_oin[k];
            r_re[k]  <= w_rin[k];
            r_im[k]  <= w_iin[k];
          end
        end
      end
    end
  end

  logic                 w_out_xfer;
  logic                 r_stk;
  logic [CNT_WIDTH-1:0] r_cnt;

  assign w_out_xfer = r_vld[PIPE-1] & i_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stk <= 1'b0;
      r_cnt <= '0;
    end else if (i_clr) begin
      r_stk <= 1'b0;
      r_cnt <= '0;
    end else if (w_out_xfer && r_ovf[PIPE-1]) begin
      r_stk <= 1'b1;
      if (r_cnt != '1) r_cnt <= r_cnt + CNT_WIDTH'(1);
    end
  end

  assign o_ready      = w_ld[0];
  assign o_valid      = r_vld[PIPE-1];
  assign o_re         = r_re[PIPE-1];
  assign o_im         = r_im[PIPE-1];
  assign o_ovf        = r_ovf[PIPE-1];
  assign o_ovf_sticky = r_stk;
  assign o_ovf_cnt    = r_cnt;

endmodule

// File: tb/tb_cplx_sgninv_pipe.sv
// Bench for cplx_sgninv_pipe: three instances (PIPE=2/SAT=1, PIPE=1/SAT=0, PIPE=4/SAT=1)
// share stimulus; each is tracked by its own queue-based reference model.
module tb_cplx_sgninv_pipe;
  localparam int W    = 16;
  localparam int ND   = 3;
  localparam int MINV = -(2**(W-1));
  localparam int MAXV = 2**(W-1) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, i_valid, i_ready, i_clr;
  logic [1:0]   i_mode;
  logic [W-1:0] i_re, i_im;
  logic         ordy [ND];
  logic         ovld [ND];
  logic         oovf [ND];
  logic         ostk [ND];
  logic [W-1:0] ore  [ND];
  logic [W-1:0] oim  [ND];
  logic [7:0]   ocnt [ND];

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  bit chk_lat = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  cplx_sgninv_pipe #(.DATA_WIDTH(W), .PIPE(2), .SAT(1'b1), .CNT_WIDTH(8)) u_p2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(ordy[0]), .i_mode(i_mode),
    .i_re(i_re), .i_im(i_im), .o_valid(ovld[0]), .i_ready(i_ready), .o_re(ore[0]),
    .o_im(oim[0]), .o_ovf(oovf[0]), .i_clr(i_clr), .o_ovf_sticky(ostk[0]), .o_ovf_cnt(ocnt[0]));
  cplx_sgninv_pipe #(.DATA_WIDTH(W), .PIPE(1), .SAT(1'b0), .CNT_WIDTH(8)) u_p1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(ordy[1]), .i_mode(i_mode),
    .i_re(i_re), .i_im(i_im), .o_valid(ovld[1]), .i_ready(i_ready), .o_re(ore[1]),
    .o_im(oim[1]), .o_ovf(oovf[1]), .i_clr(i_clr), .o_ovf_sticky(ostk[1]), .o_ovf_cnt(ocnt[1]));
  cplx_sgninv_pipe #(.DATA_WIDTH(W), .PIPE(4), .SAT(1'b1), .CNT_WIDTH(8)) u_p4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(ordy[2]), .i_mode(i_mode),
    .i_re(i_re), .i_im(i_im), .o_valid(ovld[2]), .i_ready(i_ready), .o_re(ore[2]),
    .o_im(oim[2]), .o_ovf(oovf[2]), .i_clr(i_clr), .o_ovf_sticky(ostk[2]), .o_ovf_cnt(ocnt[2]));

  function automatic int pipe_of(int d);
    return (d == 0) ? 2 : (d == 1) ? 1 : 4;
  endfunction

  function automatic bit sat_of(int d);
    return d != 1;
  endfunction

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: complex arithmetic on plain integers.
  typedef struct { int re; int im; bit ovf; int cyc; } beat_t;

  function automatic int neg(int x, bit sat);
    if (x == MINV) return sat ? MAXV : MINV;
    return -x;
  endfunction

  function automatic beat_t model(logic [1:0] m, int re, int im, bit sat);
    beat_t b;
    b.cyc = 0;
    case (m)
      2'd0:    begin b.re = re;           b.im = im;           b.ovf = 1'b0; end
      2'd1:    begin b.re = neg(re, sat); b.im = neg(im, sat); b.ovf = (re == MINV) || (im == MINV); end
      2'd2:    begin b.re = re;           b.im = neg(im, sat); b.ovf = (im == MINV); end
      default: begin b.re = im;           b.im = neg(re, sat); b.ovf = (re == MINV); end
    endcase
    return b;
  endfunction

  beat_t        q     [ND][$];
  int           m_cnt [ND];
  bit           m_stk [ND];
  bit           hold  [ND];
  logic [W-1:0] h_re  [ND];
  logic [W-1:0] h_im  [ND];
  logic         h_ovf [ND];
  int           n_out [ND];

  initial for (int d = 0; d < ND; d++) begin
    m_cnt[d] = 0; m_stk[d] = 0; hold[d] = 0; n_out[d] = 0;
  end

  // Inputs only change just after posedge, so the negedge view predicts the coming edge.
  always @(negedge clk) begin
    for (int d = 0; d < ND; d++) begin
      if (!rst_n) begin
        q[d].delete();
        m_cnt[d] = 0;
        m_stk[d] = 0;
        hold[d]  = 0;
      end else begin
        beat_t e;
        chk($sformatf("ovf_cnt[%0d]", d), ocnt[d], m_cnt[d]);
        chk($sformatf("sticky[%0d]", d), ostk[d], m_stk[d]);
        if (hold[d]) begin
          chk($sformatf("hold_valid[%0d]", d), ovld[d], 1);
          chk($sformatf("hold_re[%0d]", d), $signed(ore[d]), $signed(h_re[d]));
          chk($sformatf("hold_im[%0d]", d), $signed(oim[d]), $signed(h_im[d]));
          chk($sformatf("hold_ovf[%0d]", d), oovf[d], h_ovf[d]);
        end
        hold[d]  = ovld[d] && !i_ready;
        h_re[d]  = ore[d];
        h_im[d]  = oim[d];
        h_ovf[d] = oovf[d];
        if (ovld[d] && i_ready) begin
          if (q[d].size() == 0) begin
            chk($sformatf("spurious_out[%0d]", d), ovld[d], 0);
          end else begin
            e = q[d].pop_front();
            n_out[d]++;
            chk($sformatf("out_re[%0d]", d), $signed(ore[d]), e.re);
            chk($sformatf("out_im[%0d]", d), $signed(oim[d]), e.im);
            chk($sformatf("out_ovf[%0d]", d), oovf[d], e.ovf);
            if (chk_lat) chk($sformatf("latency[%0d]", d), cyc - e.cyc, pipe_of(d));
            if (e.ovf) begin
              m_stk[d] = 1'b1;
              if (m_cnt[d] < 255) m_cnt[d]++;
            end
          end
        end
        if (i_clr) begin
          m_cnt[d] = 0;
          m_stk[d] = 0;
        end
        if (i_valid && ordy[d]) begin
          e = model(i_mode, $signed(i_re), $signed(i_im), sat_of(d));
          e.cyc = cyc;
          q[d].push_back(e);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic step_acc(output bit acc);
    @(negedge clk);
    acc = i_valid && ordy[0];
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] rnd();
    if ($urandom_range(7) == 0) return W'(MINV);
    return W'($urandom);
  endfunction

  int er [4] = '{100, -100, 100, -37};
  int ei [4] = '{-37, 37, 37, -100};

  initial begin
    #1_000_000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    bit acc;
    int sent, base;
    rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b1; i_clr = 1'b0;
    i_mode = 2'd0; i_re = '0; i_im = '0;

    // Reset state
    repeat (3) step();
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("rst_valid[%0d]", d), ovld[d], 0);
      chk($sformatf("rst_re[%0d]", d), ore[d], 0);
      chk($sformatf("rst_im[%0d]", d), oim[d], 0);
      chk($sformatf("rst_ovf[%0d]", d), oovf[d], 0);
      chk($sformatf("rst_cnt[%0d]", d), ocnt[d], 0);
      chk($sformatf("rst_sticky[%0d]", d), ostk[d], 0);
    end
    rst_n = 1'b1;
    #1;
    chk("rst_ready", ordy[0], 1);

    // Four modes back to back on re=100, im=-37
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin
        i_valid = 1'b1; i_mode = 2'(i); i_re = W'(100); i_im = W'(-37);
      end else begin
        i_valid = 1'b0;
      end
      step();
      if (i >= 1 && i <= 4) begin
        chk($sformatf("mode%0d_valid", i-1), ovld[0], 1);
        chk($sformatf("mode%0d_re", i-1), $signed(ore[0]), er[i-1]);
        chk($sformatf("mode%0d_im", i-1), $signed(oim[0]), ei[i-1]);
        chk($sformatf("mode%0d_ovf", i-1), oovf[0], 0);
      end else if (i == 5) begin
        chk("mode_drained", ovld[0], 0);
      end
    end

    // Negating the most-negative code on both components
    i_valid = 1'b1; i_mode = 2'd1; i_re = W'(MINV); i_im = W'(MINV);
    step();
    i_valid = 1'b0;
    chk("wrap_re", $signed(ore[1]), MINV);
    chk("wrap_im", $signed(oim[1]), MINV);
    chk("wrap_ovf", oovf[1], 1);
    step();
    chk("sat_re", $signed(ore[0]), MAXV);
    chk("sat_im", $signed(oim[0]), MAXV);
    chk("sat_ovf", oovf[0], 1);
    step();
    chk("sat_cnt", ocnt[0], 1);
    chk("sat_sticky", ostk[0], 1);
    chk("wrap_cnt", ocnt[1], 1);
    repeat (4) step();

    // Backpressure: 10 beats, i_ready low for cycles 3..7
    sent = 0;
    base = n_out[0];
    for (int c = 0; c < 40 && (sent < 10 || n_out[0] - base < 10); c++) begin
      i_ready = !(c >= 3 && c <= 7);
      i_valid = (sent < 10);
      i_mode  = 2'(sent % 4);
      i_re    = W'(1000 + sent * 7);
      i_im    = W'(-sent - 1);
      step_acc(acc);
      if (acc) sent++;
      if (c == 7) begin
        chk("stall_oready", ordy[0], 0);
        chk("stall_ovalid", ovld[0], 1);
      end
    end
    i_valid = 1'b0; i_ready = 1'b1;
    chk("stall_out_count", n_out[0] - base, 10);
    repeat (6) step();

    // Counter saturation, then clear on an overflowing output transfer
    i_valid = 1'b1; i_mode = 2'd1; i_re = W'(MINV); i_im = '0;
    repeat (260) step();
    i_valid = 1'b0;
    repeat (6) step();
    chk("cnt_sat", ocnt[0], 255);
    chk("cnt_sat_p4", ocnt[2], 255);
    chk("cnt_sat_sticky", ostk[0], 1);
    i_valid = 1'b1;
    step();
    i_valid = 1'b0;
    step();
    chk("clr_pre_valid", ovld[0], 1);
    i_clr = 1'b1;
    step();
    i_clr = 1'b0;
    chk("clr_cnt", ocnt[0], 0);
    chk("clr_sticky", ostk[0], 0);
    repeat (6) step();

    // Reset with two beats in flight
    i_valid = 1'b1; i_mode = 2'd0; i_re = W'(11); i_im = W'(22);
    step();
    i_re = W'(33); i_im = W'(44);
    step();
    i_valid = 1'b0;
    chk("mid_pre_valid", ovld[0], 1);
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("mid_valid[%0d]", d), ovld[d], 0);
      chk($sformatf("mid_re[%0d]", d), ore[d], 0);
      chk($sformatf("mid_im[%0d]", d), oim[d], 0);
    end
    step();
    rst_n = 1'b1;
    i_valid = 1'b1; i_mode = 2'd2; i_re = W'(5); i_im = W'(6);
    step();
    i_valid = 1'b0;
    chk("post_rst_early", ovld[0], 0);
    step();
    chk("post_rst_valid", ovld[0], 1);
    chk("post_rst_re", $signed(ore[0]), 5);
    chk("post_rst_im", $signed(oim[0]), -6);
    repeat (6) step();

    // Randomized traffic with backpressure and occasional clears
    for (int c = 0; c < 2000; c++) begin
      i_valid = ($urandom_range(9) < 7);
      i_ready = ($urandom_range(9) < 7);
      i_clr   = ($urandom_range(49) == 0);
      i_mode  = 2'($urandom_range(3));
      i_re    = rnd();
      i_im    = rnd();
      step();
    end
    i_valid = 1'b0; i_ready = 1'b1; i_clr = 1'b0;
    repeat (8) step();
    for (int d = 0; d < ND; d++) chk($sformatf("rand_drain[%0d]", d), q[d].size(), 0);

    // Unstalled streaming: latency must equal PIPE
    chk_lat = 1'b1;
    for (int c = 0; c < 50; c++) begin
      i_valid = 1'b1;
      i_mode  = 2'($urandom_range(3));
      i_re    = rnd();
      i_im    = rnd();
      step();
    end
    i_valid = 1'b0;
    repeat (8) step();
    chk_lat = 1'b0;
    for (int d = 0; d < ND; d++) chk($sformatf("lat_drain[%0d]", d), q[d].size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
